// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: generates mic_clk, boxcar-decimates one or two PDM channels
// into unsigned ones-count PCM words behind a valid/ready hold register with overrun flag.
module pdm_mic_rx #(
  parameter int CLK_DIV = 32,
  parameter int DECIM   = 64,
  parameter bit STEREO  = 1'b0,
  parameter bit LRSEL   = 1'b0,
  localparam int OUT_W  = $clog2(DECIM + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic             mic_clk,
  output logic             mic_lrsel,
  input  logic             mic_data,
  output logic [OUT_W-1:0] pcm_l,
  output logic [OUT_W-1:0] pcm_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DECIM);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_CH0  = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DECIM - 1);

  function automatic logic [OUT_W-1:0] add_bit(input logic [OUT_W-1:0] acc, input logic b);
    return acc + {{(OUT_W-1){1'b0}}, b};
  endfunction

  // run_q is low on the first enabled cycle so div_cnt and mic_clk start aligned at 0 / high.
  logic             run_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             mic_clk_q, mic_clk_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [OUT_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic [OUT_W-1:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic             valid_q, valid_d, ovr_q, ovr_d;
  logic             ch0_pt, ch1_pt, win_end;

  always_comb begin
    ch0_pt    = en && run_q && (div_cnt_q == DIV_CH0);
    ch1_pt    = en && run_q && (div_cnt_q == DIV_LAST);
    win_end   = ch1_pt && (bit_cnt_q == BIT_LAST);
    div_cnt_d = '0;
    mic_clk_d = 1'b0;
    bit_cnt_d = '0;
    acc0_d    = '0;
    acc1_d    = '0;
    pcm_l_d   = pcm_l_q;
    pcm_r_d   = pcm_r_q;
    if (en) begin
      if (run_q && (div_cnt_q != DIV_LAST)) div_cnt_d = div_cnt_q + 1'b1;
      mic_clk_d = (div_cnt_d < DIV_HALF);
      bit_cnt_d = bit_cnt_q;
      acc0_d    = acc0_q;
      acc1_d    = acc1_q;
      if (ch0_pt) acc0_d = add_bit(acc0_q, mic_data);
      if (ch1_pt) begin
        if (STEREO) acc1_d = add_bit(acc1_q, mic_data);
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      // The ch1 bit of the final period is folded straight into the output word.
      if (win_end) begin
        pcm_l_d   = acc0_q;
        pcm_r_d   = STEREO ? add_bit(acc1_q, mic_data) : '0;
        acc0_d    = '0;
        acc1_d    = '0;
        bit_cnt_d = '0;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (win_end) valid_d = 1'b1;
    ovr_d = ovr_q;
    if (clr_overrun) ovr_d = 1'b0;
    if (win_end && valid_q && !out_ready) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      div_cnt_q <= '0;
      mic_clk_q <= 1'b0;
      bit_cnt_q <= '0;
      acc0_q    <= '0;
      acc1_q    <= '0;
      pcm_l_q   <= '0;
      pcm_r_q   <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      run_q     <= en;
      div_cnt_q <= div_cnt_d;
      mic_clk_q <= mic_clk_d;
      bit_cnt_q <= bit_cnt_d;
      acc0_q    <= acc0_d;
      acc1_q    <= acc1_d;
      pcm_l_q   <= pcm_l_d;
      pcm_r_q   <= pcm_r_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign mic_clk   = mic_clk_q;
  assign mic_lrsel = STEREO ? 1'b0 : LRSEL;
  assign pcm_l     = pcm_l_q;
  assign pcm_r     = pcm_r_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Directed bench for pdm_mic_rx: stereo and mono instances (CLK_DIV=4, DECIM=8) share stimulus.
module tb_pdm_mic_rx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic out_ready = 1'b0;
  logic clr_overrun = 1'b0;
  logic mic_data;
  int   mode = 0;
  logic tog = 1'b0;

  logic       st_mclk, st_lrsel, st_v, st_ovr;
  logic [3:0] st_l, st_r;
  logic       mo_mclk, mo_lrsel, mo_v, mo_ovr;
  logic [3:0] mo_l, mo_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // mode 0: all ones, 1: high during mic_clk high, 2: alternate per mic_clk period, 3: zeros
  always @(posedge mo_mclk) tog <= ~tog;
  assign mic_data = (mode == 0) ? 1'b1 : (mode == 1) ? st_mclk : (mode == 2) ? tog : 1'b0;

  pdm_mic_rx #(.CLK_DIV(4), .DECIM(8), .STEREO(1'b1), .LRSEL(1'b0)) u_st (
    .clk(clk), .reset_n(reset_n), .en(en), .mic_clk(st_mclk), .mic_lrsel(st_lrsel),
    .mic_data(mic_data), .pcm_l(st_l), .pcm_r(st_r), .out_valid(st_v),
    .out_ready(out_ready), .overrun(st_ovr), .clr_overrun(clr_overrun));

  pdm_mic_rx #(.CLK_DIV(4), .DECIM(8), .STEREO(1'b0), .LRSEL(1'b1)) u_mo (
    .clk(clk), .reset_n(reset_n), .en(en), .mic_clk(mo_mclk), .mic_lrsel(mo_lrsel),
    .mic_data(mic_data), .pcm_l(mo_l), .pcm_r(mo_r), .out_valid(mo_v),
    .out_ready(out_ready), .overrun(mo_ovr), .clr_overrun(clr_overrun));

  typedef struct {
    int   mode;
    logic rdy;
    int   cyc;
    logic v;
    int   sl, sr, ml, mr;
    logic ovr;
    logic mclk;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release lands on a negedge; the following posedge is the first mic_clk rise.
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{0, 1'b1,  1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1};
    vecs[1] = '{0, 1'b1, 32, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{0, 1'b1, 33, 1'b1, 8, 8, 8, 0, 1'b0, 1'b1};
    vecs[3] = '{0, 1'b1, 34, 1'b0, 8, 8, 8, 0, 1'b0, 1'b1};
    vecs[4] = '{0, 1'b1, 65, 1'b1, 8, 8, 8, 0, 1'b0, 1'b1};
    vecs[5] = '{1, 1'b1, 33, 1'b1, 8, 0, 8, 0, 1'b0, 1'b1};
    vecs[6] = '{2, 1'b1, 33, 1'b1, 4, 4, 4, 0, 1'b0, 1'b1};
    vecs[7] = '{3, 1'b1, 33, 1'b1, 0, 0, 0, 0, 1'b0, 1'b1};
    vecs[8] = '{0, 1'b0, 64, 1'b1, 8, 8, 8, 0, 1'b0, 1'b0};
    vecs[9] = '{0, 1'b0, 65, 1'b1, 8, 8, 8, 0, 1'b1, 1'b1};

    #1;
    chk("rst.mic_clk", st_mclk, 0);
    chk("rst.valid", st_v, 0);
    chk("rst.pcm_l", st_l, 0);
    chk("rst.overrun", st_ovr, 0);
    chk("lrsel.stereo", st_lrsel, 0);
    chk("lrsel.mono", mo_lrsel, 1);

    for (int i = 0; i < 10; i++) begin
      mode = vecs[i].mode;
      out_ready = vecs[i].rdy;
      en = 1'b1;
      clr_overrun = 1'b0;
      do_reset();
      wait_cyc(vecs[i].cyc);
      chk($sformatf("v%0d.st_valid", i), st_v, vecs[i].v);
      chk($sformatf("v%0d.mo_valid", i), mo_v, vecs[i].v);
      chk($sformatf("v%0d.pcm_l", i), st_l, vecs[i].sl);
      chk($sformatf("v%0d.pcm_r", i), st_r, vecs[i].sr);
      chk($sformatf("v%0d.mono_l", i), mo_l, vecs[i].ml);
      chk($sformatf("v%0d.mono_r", i), mo_r, vecs[i].mr);
      chk($sformatf("v%0d.overrun", i), st_ovr, vecs[i].ovr);
      chk($sformatf("v%0d.mic_clk", i), st_mclk, vecs[i].mclk);
    end

    // Overrun keeps the newest sample; clear, set-beats-clear, load-with-transfer.
    mode = 3; out_ready = 1'b0; en = 1'b1; clr_overrun = 1'b0;
    do_reset();
    wait_cyc(33);
    chk("ovr.first_valid", st_v, 1);
    chk("ovr.first_l", st_l, 0);
    mode = 0;
    wait_cyc(32);
    chk("ovr.set", st_ovr, 1);
    chk("ovr.second_l", st_l, 8);
    chk("ovr.second_r", st_r, 8);
    clr_overrun = 1'b1;
    wait_cyc(1);
    clr_overrun = 1'b0;
    chk("ovr.cleared", st_ovr, 0);
    chk("ovr.valid_kept", st_v, 1);
    wait_cyc(30);
    clr_overrun = 1'b1;
    wait_cyc(1);
    clr_overrun = 1'b0;
    chk("ovr.set_wins", st_ovr, 1);
    clr_overrun = 1'b1;
    wait_cyc(1);
    clr_overrun = 1'b0;
    chk("ovr.cleared2", st_ovr, 0);
    wait_cyc(30);
    out_ready = 1'b1;
    wait_cyc(1);
    chk("ovr.xfer_load_valid", st_v, 1);
    chk("ovr.xfer_no_ovr", st_ovr, 0);
    wait_cyc(1);
    chk("ovr.xfer_drop", st_v, 0);

    // Asynchronous reset in the middle of the second window (bit_cnt=5).
    mode = 0; out_ready = 1'b0; en = 1'b1;
    do_reset();
    wait_cyc(54);
    chk("mrst.pre_valid", st_v, 1);
    reset_n = 1'b0;
    #1;
    chk("mrst.valid", st_v, 0);
    chk("mrst.pcm_l", st_l, 0);
    chk("mrst.pcm_r", st_r, 0);
    chk("mrst.overrun", st_ovr, 0);
    chk("mrst.mic_clk", st_mclk, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(1);
    chk("mrst.rise", st_mclk, 1);
    wait_cyc(31);
    chk("mrst.valid_early", st_v, 0);
    wait_cyc(1);
    chk("mrst.valid_on_time", st_v, 1);
    chk("mrst.pcm_l_new", st_l, 8);

    // Disable mid-window: clock parks low, pending sample readable, restart discards partial.
    mode = 0; out_ready = 1'b0; en = 1'b1;
    do_reset();
    wait_cyc(43);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_cyc(1);
      chk($sformatf("en0.mic_clk%0d", k), st_mclk, 0);
    end
    chk("en0.valid_held", st_v, 1);
    chk("en0.pcm_l_held", st_l, 8);
    out_ready = 1'b1;
    wait_cyc(1);
    out_ready = 1'b0;
    chk("en0.consumed", st_v, 0);
    mode = 3;
    en = 1'b1;
    wait_cyc(1);
    chk("en1.rise", st_mclk, 1);
    wait_cyc(31);
    chk("en1.valid_early", st_v, 0);
    wait_cyc(1);
    chk("en1.valid", st_v, 1);
    chk("en1.pcm_l_fresh", st_l, 0);
    chk("en1.pcm_r_fresh", st_r, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
